// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit                                                 |
// | Description : Iterative multiply / divide unit beside the execute-stage    |
// |               ALU. One shift-add (multiply) or shift-subtract (restoring   |
// |               divide) step per cycle, then a sign-fix cycle, then a       |
// |               one-cycle done pulse. Start/busy/done handshake.             |
// | Config      : define MULDIV_DIV_EN to build the divider (DIVU/DIVS);       |
// |               otherwise divide opcodes finish at once with illegal = 1.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]      r_cnt;
  // r_acc: product high half / partial remainder.
  // r_q  : multiplier shifting out / dividend shifting out, quotient shifting in.
  // r_b  : multiplicand / divisor magnitude.
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_negq;   // negate product / quotient in FIX
  logic               r_short;  // result was decided at start, no iteration
  logic               r_dbz;
  logic               r_ill;

  logic               w_accept;
  logic               w_short;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

`ifdef MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_negr;   // remainder follows the dividend sign
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_ddiff;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
`endif

  // Start is only honoured when no operation is in flight.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Ops that skip the iteration: zero divisor, or any divide when no divider exists.
`ifdef MULDIV_DIV_EN
  assign w_short = op[1] && (B == '0);
`else
  assign w_short = op[1];
`endif

  // op[0] selects signed operation; work on magnitudes and fix signs at the end.
  assign w_a_mag = (op[0] && A[WIDTH-1]) ? -A : A;
  assign w_b_mag = (op[0] && B[WIDTH-1]) ? -B : B;

  // Multiply step: conditionally add multiplicand, then shift {carry,acc,q} right.
  assign w_msum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_negq ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
  // Restoring divide step: shift next dividend bit in, trial-subtract divisor.
  assign w_dshift   = {r_acc, r_q[WIDTH-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_b};
  assign w_quot_fix = r_negq ? -r_q : r_q;
  assign w_rem_fix  = r_negr ? -r_acc : r_acc;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_short ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  begin
        if (start) w_next = w_short ? S_FIX : S_RUN;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, register results in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_negq   <= 1'b0;
      r_short  <= 1'b0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_negr   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_dbz   <= 1'b0;
      r_ill   <= 1'b0;
      r_acc   <= '0;
      r_short <= w_short;
      r_negq  <= op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MULDIV_DIV_EN
      r_is_div <= op[1];
      r_negr   <= op[0] & A[WIDTH-1];
      if (w_short) begin
        // Zero divisor: quotient all ones, remainder is the raw dividend.
        r_q   <= '1;
        r_acc <= A;
      end else if (op[1]) begin
        r_q <= w_a_mag;
        r_b <= w_b_mag;
      end else begin
        r_q <= w_b_mag;
        r_b <= w_a_mag;
      end
`else
      if (w_short) begin
        r_q <= '0;
      end else begin
        r_q <= w_b_mag;
        r_b <= w_a_mag;
      end
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            if (!w_ddiff[WIDTH]) begin
              r_acc <= w_ddiff[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= w_dshift[WIDTH-1:0];
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
          end else
`endif
          begin
            r_acc <= w_msum[WIDTH:1];
            r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (r_short) begin
            r_lo  <= r_q;
            r_hi  <= r_acc;
`ifdef MULDIV_DIV_EN
            r_dbz <= 1'b1;
`else
            r_ill <= 1'b1;
`endif
          end
`ifdef MULDIV_DIV_EN
          else if (r_is_div) begin
            r_lo <= w_quot_fix;
            r_hi <= w_rem_fix;
          end
`endif
          else begin
            r_lo <= w_prod_fix[WIDTH-1:0];
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign lo          = r_lo;
  assign hi          = r_hi;
  assign div_by_zero = r_dbz;
  assign illegal     = r_ill;

endmodule
`default_nettype wire
